// File: rtl/usb_token_crc_seq_if.sv
// rtl/usb_token_crc_seq_if.sv - token request and serial tx bundle between host FSM, sequencer and tx stage
interface usb_token_crc_seq_if;
  logic       req_valid;
  logic       req_ready;
  logic [7:0] req_pid;
  logic [6:0] req_addr;
  logic [3:0] req_endp;
  logic       tx_bit;
  logic       tx_valid;

  // Host side: issues token requests and observes the serial stream.
  modport master (
    output req_valid, req_pid, req_addr, req_endp,
    input  req_ready, tx_bit, tx_valid
  );

  // Sequencer side.
  modport slave (
    input  req_valid, req_pid, req_addr, req_endp,
    output req_ready, tx_bit, tx_valid
  );
endinterface

// File: rtl/usb_token_crc_seq.sv
// rtl/usb_token_crc_seq.sv - USB token packet sequencer around a bit-serial CRC5 engine (option: USB_TOKEN_CRC_CHECK_EN)
module usb_token_crc_seq #(
  parameter int TIMEOUT  = 16,
  parameter bit EMIT_PID = 1'b1
) (
  input  logic               clk,
  input  logic               rst,
  usb_token_crc_seq_if.slave bus,
  output logic               crc_start,
  output logic               crc_s_in,
  input  logic               crc_out,
  input  logic               crc_ready,
  input  logic               crc_done,
  output logic               crc_rec,
  output logic [4:0]         crc_q,
  output logic               pkt_done,
  output logic               pkt_err,
  output logic               crc_mismatch
);

  localparam int TO_W = $clog2(TIMEOUT + 1);
  localparam logic [TO_W-1:0] TO_MAX  = TO_W'(TIMEOUT);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_PID, S_DATA, S_WAIT_RDY, S_CRC, S_WAIT_DONE, S_ACK, S_ABORT
  } state_t;

  state_t          state_q, state_d;
  logic [4:0]      bit_cnt_q, bit_cnt_d;
  logic [TO_W-1:0] to_cnt_q, to_cnt_d;
  logic [7:0]      pid_q, pid_d;
  logic [10:0]     data_q, data_d;
  logic [10:0]     data_sh;
  logic [4:0]      crc_reg_q, crc_reg_d;
  logic            mismatch_q, mismatch_d;
  logic            req_ready_q, req_ready_d;
  logic            tx_valid_q, tx_valid_d;
  logic            tx_bit_q, tx_bit_d;
  logic            crc_start_q, crc_start_d;
  logic            crc_s_in_q, crc_s_in_d;
  logic            crc_rec_q, crc_rec_d;
  logic            pkt_done_q, pkt_done_d;
  logic            pkt_err_q, pkt_err_d;

`ifdef USB_TOKEN_CRC_CHECK_EN
  // Reference CRC5 over the 11 data bits, LSB first; result bit 4 is the first bit on the wire.
  function automatic logic [4:0] crc5_model(input logic [10:0] d);
    logic [4:0] r;
    logic       fb;
    r = 5'h1F;
    for (int i = 0; i < 11; i++) begin
      fb = d[i] ^ r[4];
      r  = {r[3:0], 1'b0};
      if (fb) r = r ^ 5'h05;
    end
    return ~r;
  endfunction
`endif

  // Next-state, counters and the registered-output values for the coming cycle.
  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    to_cnt_d   = to_cnt_q;
    pid_d      = pid_q;
    data_d     = data_q;
    crc_reg_d  = crc_reg_q;
    mismatch_d = mismatch_q;

    case (state_q)
      S_IDLE: begin
        if (bus.req_valid) begin
          pid_d      = bus.req_pid;
          data_d     = {bus.req_endp, bus.req_addr};
          mismatch_d = 1'b0;
          bit_cnt_d  = 5'd0;
          state_d    = EMIT_PID ? S_PID : S_DATA;
        end
      end
      S_PID: begin
        if (bit_cnt_q == 5'd7) begin
          state_d   = S_DATA;
          bit_cnt_d = 5'd0;
        end else begin
          bit_cnt_d = bit_cnt_q + 5'd1;
        end
      end
      S_DATA: begin
        if (bit_cnt_q == 5'd10) begin
          state_d   = S_WAIT_RDY;
          bit_cnt_d = 5'd0;
          to_cnt_d  = '0;
        end else begin
          bit_cnt_d = bit_cnt_q + 5'd1;
        end
      end
      S_WAIT_RDY: begin
        // crc_ready is checked first so it wins over a simultaneous expiry.
        if (crc_ready) begin
          state_d   = S_CRC;
          bit_cnt_d = 5'd0;
        end else if (to_cnt_q == TO_LAST) begin
          state_d = S_ABORT;
        end else if (to_cnt_q != TO_MAX) begin
          to_cnt_d = to_cnt_q + TO_W'(1);
        end
      end
      S_CRC: begin
        if (!crc_ready) begin
          state_d = S_ABORT;
        end else begin
          crc_reg_d = {crc_reg_q[3:0], crc_out};
          if (bit_cnt_q == 5'd4) begin
            bit_cnt_d = 5'd0;
            to_cnt_d  = '0;
            state_d   = crc_done ? S_ACK : S_WAIT_DONE;
          end else begin
            bit_cnt_d = bit_cnt_q + 5'd1;
          end
        end
      end
      S_WAIT_DONE: begin
        if (crc_done) begin
          state_d   = S_ACK;
          bit_cnt_d = 5'd0;
        end else if (to_cnt_q == TO_LAST) begin
          state_d = S_ABORT;
        end else if (to_cnt_q != TO_MAX) begin
          to_cnt_d = to_cnt_q + TO_W'(1);
        end
      end
      S_ACK: begin
`ifdef USB_TOKEN_CRC_CHECK_EN
        mismatch_d = (crc5_model(data_q) != crc_reg_q);
`endif
        state_d   = S_IDLE;
        bit_cnt_d = 5'd0;
      end
      S_ABORT: begin
        state_d   = S_IDLE;
        bit_cnt_d = 5'd0;
      end
      default: begin
        state_d   = S_IDLE;
        bit_cnt_d = 5'd0;
      end
    endcase

    // Outputs are a function of the state being entered so they line up with it.
    data_sh     = data_d >> bit_cnt_d;
    req_ready_d = (state_d == S_IDLE);
    tx_valid_d  = (state_d == S_PID) || (state_d == S_DATA) || (state_d == S_CRC);
    crc_start_d = (state_d == S_DATA);
    tx_bit_d    = 1'b0;
    crc_s_in_d  = 1'b0;
    if (state_d == S_PID) begin
      tx_bit_d = pid_d[bit_cnt_d[2:0]];
    end
    if (state_d == S_DATA) begin
      tx_bit_d   = data_sh[0];
      crc_s_in_d = data_sh[0];
    end
    crc_rec_d  = (state_d == S_ACK) || (state_d == S_ABORT);
    pkt_done_d = (state_d == S_ACK);
    pkt_err_d  = (state_d == S_ABORT);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      bit_cnt_q   <= 5'd0;
      to_cnt_q    <= '0;
      pid_q       <= 8'd0;
      data_q      <= 11'd0;
      crc_reg_q   <= 5'd0;
      mismatch_q  <= 1'b0;
      req_ready_q <= 1'b1;
      tx_valid_q  <= 1'b0;
      tx_bit_q    <= 1'b0;
      crc_start_q <= 1'b0;
      crc_s_in_q  <= 1'b0;
      crc_rec_q   <= 1'b0;
      pkt_done_q  <= 1'b0;
      pkt_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      to_cnt_q    <= to_cnt_d;
      pid_q       <= pid_d;
      data_q      <= data_d;
      crc_reg_q   <= crc_reg_d;
      mismatch_q  <= mismatch_d;
      req_ready_q <= req_ready_d;
      tx_valid_q  <= tx_valid_d;
      tx_bit_q    <= tx_bit_d;
      crc_start_q <= crc_start_d;
      crc_s_in_q  <= crc_s_in_d;
      crc_rec_q   <= crc_rec_d;
      pkt_done_q  <= pkt_done_d;
      pkt_err_q   <= pkt_err_d;
    end
  end

  // During CRC the engine's bit is forwarded in the same cycle it is presented.
  assign bus.tx_bit    = (state_q == S_CRC) ? crc_out : tx_bit_q;
  assign bus.tx_valid  = tx_valid_q;
  assign bus.req_ready = req_ready_q;
  assign crc_start     = crc_start_q;
  assign crc_s_in      = crc_s_in_q;
  assign crc_rec       = crc_rec_q;
  assign crc_q         = crc_reg_q;
  assign pkt_done      = pkt_done_q;
  assign pkt_err       = pkt_err_q;
  assign crc_mismatch  = mismatch_q;

endmodule

// File: tb/tb_usb_token_crc_seq.sv
// tb/tb_usb_token_crc_seq.sv - directed self-checking bench for usb_token_crc_seq
module tb_usb_token_crc_seq;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  usb_token_crc_seq_if bus1();
  usb_token_crc_seq_if bus2();

  logic       crc_out1 = 1'b0, crc_ready1 = 1'b0, crc_done1 = 1'b0;
  logic       crc_start1, crc_s_in1, crc_rec1, pkt_done1, pkt_err1, mm1;
  logic [4:0] crc_q1;
  logic       crc_out2 = 1'b0, crc_ready2 = 1'b0, crc_done2 = 1'b0;
  logic       crc_start2, crc_s_in2, crc_rec2, pkt_done2, pkt_err2, mm2;
  logic [4:0] crc_q2;

  usb_token_crc_seq #(.TIMEOUT(16), .EMIT_PID(1'b1)) dut (
    .clk(clk), .rst(rst), .bus(bus1),
    .crc_start(crc_start1), .crc_s_in(crc_s_in1), .crc_out(crc_out1),
    .crc_ready(crc_ready1), .crc_done(crc_done1), .crc_rec(crc_rec1),
    .crc_q(crc_q1), .pkt_done(pkt_done1), .pkt_err(pkt_err1), .crc_mismatch(mm1)
  );

  usb_token_crc_seq #(.TIMEOUT(16), .EMIT_PID(1'b0)) dut_nopid (
    .clk(clk), .rst(rst), .bus(bus2),
    .crc_start(crc_start2), .crc_s_in(crc_s_in2), .crc_out(crc_out2),
    .crc_ready(crc_ready2), .crc_done(crc_done2), .crc_rec(crc_rec2),
    .crc_q(crc_q2), .pkt_done(pkt_done2), .pkt_err(pkt_err2), .crc_mismatch(mm2)
  );

`ifdef USB_TOKEN_CRC_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  int n_checks = 0;
  int n_errors = 0;

  logic       a_tv [0:79], a_tb [0:79], a_cs [0:79], a_si [0:79];
  logic       a_rec [0:79], a_pd [0:79], a_pe [0:79], a_rr [0:79], a_mm [0:79];
  logic [4:0] a_cq [0:79];

  // Accepts one request at the current cycle (0) and plays an engine stub on a fixed schedule.
  task automatic run_pkt(input logic [7:0] pid, input logic [6:0] addr, input logic [3:0] endp,
                         input logic [4:0] cval, input int rdy_at, input int done_at, input bit stall,
                         input int rst_at, input int b2b, input int ncyc);
    int r, k;
    bus1.req_pid = pid; bus1.req_addr = addr; bus1.req_endp = endp; bus1.req_valid = 1'b1;
    for (int c = 0; c <= ncyc; c++) begin
      if (c > 0) begin @(posedge clk); @(negedge clk); end
      rst = (c == rst_at);
      if (c == ((b2b == 0) ? 1 : b2b + 1)) bus1.req_valid = 1'b0;
      r = (b2b > 0 && c >= b2b) ? c - b2b : c;
      if (rst_at >= 0 && c >= rst_at) begin
        crc_ready1 = 1'b0; crc_out1 = 1'b0; crc_done1 = 1'b0;
      end else begin
        k = r - rdy_at - 1;
        if (k < 0) k = 0;
        crc_ready1 = !stall && (r >= rdy_at) && (r <= rdy_at + 5);
        crc_out1   = ((r >= rdy_at) && (r <= rdy_at + 5)) ? cval[4-k] : 1'b0;
        crc_done1  = (r == done_at);
      end
      #1;
      a_tv[c] = bus1.tx_valid; a_tb[c] = bus1.tx_bit; a_cs[c] = crc_start1; a_si[c] = crc_s_in1;
      a_rec[c] = crc_rec1; a_pd[c] = pkt_done1; a_pe[c] = pkt_err1; a_rr[c] = bus1.req_ready;
      a_mm[c] = mm1; a_cq[c] = crc_q1;
    end
    bus1.req_valid = 1'b0; rst = 1'b0;
    crc_ready1 = 1'b0; crc_out1 = 1'b0; crc_done1 = 1'b0;
  endtask

  task automatic test_reset();
    logic [13:0] got;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    got = {bus1.req_ready, bus1.tx_valid, bus1.tx_bit, crc_start1, crc_s_in1, crc_rec1, pkt_done1,
           pkt_err1, mm1, crc_q1};
    n_checks++; if (got !== 14'b1_0000000_0_00000) begin n_errors++; $display("FAIL reset_outputs got %b exp %b", got, 14'b1_0000000_0_00000); end
    n_checks++; if (bus2.req_ready !== 1'b1 || bus2.tx_valid !== 1'b0) begin n_errors++; $display("FAIL reset_nopid got rr=%b tv=%b exp rr=1 tv=0", bus2.req_ready, bus2.tx_valid); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_tx_stream();
    logic [7:0]  pids [2];
    logic [6:0]  addrs [2];
    logic [3:0]  endps [2];
    logic [4:0]  cvals [2];
    logic [23:0] streams [2];
    int          rdys [2], dones [2], acks [2];
    logic        etv, ecs, ebit;
    int          idx;
    pids[0] = 8'hE1; addrs[0] = 7'h00; endps[0] = 4'h1; cvals[0] = 5'b01100;
    rdys[0] = 20; dones[0] = 26; acks[0] = 27; streams[0] = 24'b10000111_00000001000_01100;
    pids[1] = 8'h69; addrs[1] = 7'h15; endps[1] = 4'hA; cvals[1] = 5'b10110;
    rdys[1] = 23; dones[1] = 28; acks[1] = 29; streams[1] = 24'b10010110_10101000101_10110;
    for (int e = 0; e < 2; e++) begin
      run_pkt(pids[e], addrs[e], endps[e], cvals[e], rdys[e], dones[e], 1'b0, -1, 0, acks[e] + 2);
      for (int c = 0; c <= acks[e] + 2; c++) begin
        etv = (c >= 1 && c <= 19) || (c > rdys[e] && c <= rdys[e] + 5);
        ecs = (c >= 9 && c <= 19);
        idx = (c <= 19) ? c - 1 : c - rdys[e] + 18;
        ebit = 1'b0;
        n_checks++; if (a_tv[c] !== etv) begin n_errors++; $display("FAIL stream%0d_tx_valid c=%0d got %b exp %b", e, c, a_tv[c], etv); end
        if (etv) begin
          ebit = streams[e][23-idx];
          n_checks++; if (a_tb[c] !== ebit) begin n_errors++; $display("FAIL stream%0d_tx_bit c=%0d got %b exp %b", e, c, a_tb[c], ebit); end
        end
        n_checks++; if (a_cs[c] !== ecs) begin n_errors++; $display("FAIL stream%0d_crc_start c=%0d got %b exp %b", e, c, a_cs[c], ecs); end
        if (ecs) begin
          n_checks++; if (a_si[c] !== ebit) begin n_errors++; $display("FAIL stream%0d_crc_s_in c=%0d got %b exp %b", e, c, a_si[c], ebit); end
        end
        n_checks++; if (a_pd[c] !== (c == acks[e])) begin n_errors++; $display("FAIL stream%0d_pkt_done c=%0d got %b exp %b", e, c, a_pd[c], c == acks[e]); end
        n_checks++; if (a_rec[c] !== (c == acks[e])) begin n_errors++; $display("FAIL stream%0d_crc_rec c=%0d got %b exp %b", e, c, a_rec[c], c == acks[e]); end
        n_checks++; if (a_pe[c] !== 1'b0) begin n_errors++; $display("FAIL stream%0d_pkt_err c=%0d got %b exp 0", e, c, a_pe[c]); end
        n_checks++; if (a_rr[c] !== (c == 0 || c > acks[e])) begin n_errors++; $display("FAIL stream%0d_req_ready c=%0d got %b exp %b", e, c, a_rr[c], c == 0 || c > acks[e]); end
      end
      n_checks++; if (a_cq[acks[e]] !== cvals[e]) begin n_errors++; $display("FAIL stream%0d_crc_q got %b exp %b", e, a_cq[acks[e]], cvals[e]); end
      n_checks++; if (a_mm[1] !== 1'b0) begin n_errors++; $display("FAIL stream%0d_mismatch_clear got %b exp 0", e, a_mm[1]); end
      n_checks++; if (a_mm[acks[e] + 1] !== CHK) begin n_errors++; $display("FAIL stream%0d_mismatch got %b exp %b", e, a_mm[acks[e] + 1], CHK); end
    end
  endtask

  task automatic test_back_to_back();
    logic [23:0] s;
    logic        etv;
    int          npd;
    s = 24'b10000111_00000001000_01100;
    npd = 0;
    run_pkt(8'hE1, 7'h00, 4'h1, 5'b01100, 20, 26, 1'b0, -1, 28, 56);
    n_checks++; if (a_rr[28] !== 1'b1 || a_rr[29] !== 1'b0) begin n_errors++; $display("FAIL b2b_accept got rr28=%b rr29=%b exp 1 0", a_rr[28], a_rr[29]); end
    for (int c = 1; c <= 27; c++) begin
      etv = (c <= 19) || (c >= 21 && c <= 25);
      n_checks++; if (a_tv[c + 28] !== etv) begin n_errors++; $display("FAIL b2b_tx_valid c=%0d got %b exp %b", c + 28, a_tv[c + 28], etv); end
      if (etv) begin
        n_checks++; if (a_tb[c + 28] !== s[23 - ((c <= 19) ? c - 1 : c - 2)]) begin n_errors++; $display("FAIL b2b_tx_bit c=%0d got %b exp %b", c + 28, a_tb[c + 28], s[23 - ((c <= 19) ? c - 1 : c - 2)]); end
      end
    end
    for (int c = 0; c <= 56; c++) if (a_pd[c] === 1'b1) npd++;
    n_checks++; if (a_pd[27] !== 1'b1 || a_pd[55] !== 1'b1 || npd != 2) begin n_errors++; $display("FAIL b2b_pkt_done got pd27=%b pd55=%b count=%0d exp 1 1 2", a_pd[27], a_pd[55], npd); end
  endtask

  task automatic test_stall();
    run_pkt(8'hE1, 7'h00, 4'h1, 5'b01100, 20, 26, 1'b1, -1, 0, 40);
    for (int c = 0; c <= 40; c++) begin
      n_checks++; if (a_pe[c] !== (c == 36)) begin n_errors++; $display("FAIL stall_pkt_err c=%0d got %b exp %b", c, a_pe[c], c == 36); end
      n_checks++; if (a_rec[c] !== (c == 36)) begin n_errors++; $display("FAIL stall_crc_rec c=%0d got %b exp %b", c, a_rec[c], c == 36); end
      n_checks++; if (a_pd[c] !== 1'b0) begin n_errors++; $display("FAIL stall_pkt_done c=%0d got %b exp 0", c, a_pd[c]); end
      n_checks++; if (a_rr[c] !== (c == 0 || c >= 37)) begin n_errors++; $display("FAIL stall_req_ready c=%0d got %b exp %b", c, a_rr[c], c == 0 || c >= 37); end
      if (c >= 20) begin
        n_checks++; if (a_tv[c] !== 1'b0 || a_cs[c] !== 1'b0) begin n_errors++; $display("FAIL stall_idle_outputs c=%0d got tv=%b cs=%b exp 0 0", c, a_tv[c], a_cs[c]); end
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [13:0] got;
    run_pkt(8'hE1, 7'h00, 4'h1, 5'b01100, 20, 26, 1'b0, 14, 0, 24);
    n_checks++; if (a_tv[14] !== 1'b1 || a_cs[14] !== 1'b1) begin n_errors++; $display("FAIL rstmid_busy got tv=%b cs=%b exp 1 1", a_tv[14], a_cs[14]); end
    got = {a_rr[15], a_tv[15], a_tb[15], a_cs[15], a_si[15], a_rec[15], a_pd[15], a_pe[15], a_mm[15], a_cq[15]};
    n_checks++; if (got !== 14'b1_0000000_0_00000) begin n_errors++; $display("FAIL rstmid_outputs got %b exp %b", got, 14'b1_0000000_0_00000); end
    for (int c = 14; c <= 24; c++) begin
      n_checks++; if (a_rec[c] !== 1'b0 || a_pd[c] !== 1'b0 || a_pe[c] !== 1'b0) begin n_errors++; $display("FAIL rstmid_pulses c=%0d got rec=%b pd=%b pe=%b exp 0 0 0", c, a_rec[c], a_pd[c], a_pe[c]); end
    end
    run_pkt(8'hE1, 7'h00, 4'h1, 5'b01100, 20, 26, 1'b0, -1, 0, 28);
    n_checks++; if (a_pd[27] !== 1'b1 || a_cq[27] !== 5'b01100) begin n_errors++; $display("FAIL rstmid_recover got pd=%b crc_q=%b exp 1 01100", a_pd[27], a_cq[27]); end
  endtask

  task automatic test_emit_pid0();
    logic [15:0] s;
    logic [4:0]  cv;
    logic        etv;
    int          k;
    s = 16'b10101000101_11001;
    cv = 5'b11001;
    bus2.req_pid = 8'hFF; bus2.req_addr = 7'h15; bus2.req_endp = 4'hA; bus2.req_valid = 1'b1;
    for (int c = 0; c <= 20; c++) begin
      if (c > 0) begin @(posedge clk); @(negedge clk); end
      if (c == 1) bus2.req_valid = 1'b0;
      k = c - 13;
      if (k < 0) k = 0;
      crc_ready2 = (c >= 12 && c <= 17);
      crc_out2   = (c >= 12 && c <= 17) ? cv[4-k] : 1'b0;
      crc_done2  = (c == 18);
      #1;
      etv = (c >= 1 && c <= 11) || (c >= 13 && c <= 17);
      n_checks++; if (bus2.tx_valid !== etv) begin n_errors++; $display("FAIL nopid_tx_valid c=%0d got %b exp %b", c, bus2.tx_valid, etv); end
      if (etv) begin
        n_checks++; if (bus2.tx_bit !== s[15 - ((c <= 11) ? c - 1 : c - 2)]) begin n_errors++; $display("FAIL nopid_tx_bit c=%0d got %b exp %b", c, bus2.tx_bit, s[15 - ((c <= 11) ? c - 1 : c - 2)]); end
      end
      n_checks++; if (crc_start2 !== (c >= 1 && c <= 11)) begin n_errors++; $display("FAIL nopid_crc_start c=%0d got %b exp %b", c, crc_start2, c >= 1 && c <= 11); end
      n_checks++; if (pkt_done2 !== (c == 19)) begin n_errors++; $display("FAIL nopid_pkt_done c=%0d got %b exp %b", c, pkt_done2, c == 19); end
    end
    crc_ready2 = 1'b0; crc_out2 = 1'b0; crc_done2 = 1'b0;
    n_checks++; if (crc_q2 !== 5'b11001) begin n_errors++; $display("FAIL nopid_crc_q got %b exp 11001", crc_q2); end
  endtask

  task automatic test_crc_check();
    run_pkt(8'hE1, 7'h00, 4'h1, 5'b00101, 20, 26, 1'b0, -1, 0, 30);
    n_checks++; if (a_mm[28] !== 1'b0) begin n_errors++; $display("FAIL check_match got %b exp 0", a_mm[28]); end
    run_pkt(8'hE1, 7'h00, 4'h1, 5'b00100, 20, 26, 1'b0, -1, 0, 30);
    n_checks++; if (a_mm[28] !== CHK || a_mm[30] !== CHK) begin n_errors++; $display("FAIL check_mismatch got %b %b exp %b", a_mm[28], a_mm[30], CHK); end
    run_pkt(8'h69, 7'h15, 4'hA, 5'b11101, 20, 26, 1'b0, -1, 0, 30);
    n_checks++; if (a_mm[0] !== CHK) begin n_errors++; $display("FAIL check_held got %b exp %b", a_mm[0], CHK); end
    n_checks++; if (a_mm[1] !== 1'b0 || a_mm[28] !== 1'b0) begin n_errors++; $display("FAIL check_cleared got %b %b exp 0 0", a_mm[1], a_mm[28]); end
  endtask

  initial begin
    bus1.req_valid = 1'b0; bus1.req_pid = 8'h00; bus1.req_addr = 7'h00; bus1.req_endp = 4'h0;
    bus2.req_valid = 1'b0; bus2.req_pid = 8'h00; bus2.req_addr = 7'h00; bus2.req_endp = 4'h0;
    test_reset();
    test_tx_stream();
    test_back_to_back();
    test_stall();
    test_reset_mid();
    test_emit_pid0();
    test_crc_check();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
